// File: rtl/voting_pkg.sv
// Shared widths, result codes and FSM state type for the ballot console slice.
package voting_pkg;

  localparam int ID_W       = 2;
  localparam int PASS_W     = 8;
  localparam int VOTE_W     = 2;
  localparam int NUM_VOTERS = 4;

  localparam logic [2:0] RES_OK       = 3'd0;
  localparam logic [2:0] RES_BAD_PASS = 3'd1;
  localparam logic [2:0] RES_ALREADY  = 3'd2;
  localparam logic [2:0] RES_TIMEOUT  = 3'd3;
  localparam logic [2:0] RES_LOCKED   = 3'd4;
  localparam logic [2:0] RES_BAD_VOTE = 3'd5;

  localparam logic [VOTE_W-1:0] VOTE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GAP,
    S_SUBMIT,
    S_WAIT,
    S_REPORT
  } state_t;

  // Machine flags resolve invalid_login > already_voted > vote_done.
  function automatic logic [2:0] flag_code(input logic inv, input logic already);
    if (inv) return RES_BAD_PASS;
    if (already) return RES_ALREADY;
    return RES_OK;
  endfunction

endpackage

// File: rtl/ballot_console_if.sv
// Front-end request/result handshake plus the voting_machine pulse/flag signals.
interface ballot_console_if;
  import voting_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_id;
  logic [PASS_W-1:0] req_pass;
  logic [VOTE_W-1:0] req_vote;
  logic              start;
  logic              submit;
  logic [ID_W-1:0]   voter_id;
  logic [PASS_W-1:0] password;
  logic [VOTE_W-1:0] vote;
  logic              vote_done;
  logic              invalid_login;
  logic              already_voted;
  logic              res_valid;
  logic [2:0]        res_code;
  logic              busy;

  modport master (
    input  req_valid, req_id, req_pass, req_vote,
    input  vote_done, invalid_login, already_voted,
    output req_ready, start, submit, voter_id, password, vote,
    output res_valid, res_code, busy
  );

  modport slave (
    output req_valid, req_id, req_pass, req_vote,
    output vote_done, invalid_login, already_voted,
    input  req_ready, start, submit, voter_id, password, vote,
    input  res_valid, res_code, busy
  );

endinterface

// File: rtl/voter_lockout.sv
// Per-voter saturating password-failure counters and sticky lock bits.
module voter_lockout
  import voting_pkg::*;
#(
  parameter int PASS_TRIES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] id,
  input  logic            inc,
  input  logic            clr,
  output logic            locked
);

  logic [1:0]            fails [NUM_VOTERS];
  logic [NUM_VOTERS-1:0] lock_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOTERS; i++) fails[i] <= '0;
      lock_bits <= '0;
    end else if (inc) begin
      if (fails[id] != 2'd3) fails[id] <= fails[id] + 2'd1;
      if (int'(fails[id]) + 1 >= PASS_TRIES) lock_bits[id] <= 1'b1;
    end else if (clr) begin
      // Only the counter clears; a lock is released solely by reset.
      fails[id] <= '0;
    end
  end

  assign locked = lock_bits[id];

endmodule

// File: rtl/ballot_console.sv
// Initiator-side sequencer: one ballot request -> start/submit pulses -> one result code.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | req_ready high, latch request and screen vote/lock
// S_START  | start pulse on the wire
// S_GAP    | GAP idle cycles before submit, flags sampled
// S_SUBMIT | submit pulse on the wire, flags sampled
// S_WAIT   | down-counting response window, flags sampled
// S_REPORT | res_valid pulse with res_code, lockout bookkeeping
module ballot_console
  import voting_pkg::*;
#(
  parameter int PASS_TRIES   = 3,
  parameter int GAP          = 1,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  ballot_console_if.master bus
);

  state_t          state;
  logic [7:0]      cnt;
  logic            any_flag;
  logic [2:0]      flag_res;
  logic [ID_W-1:0] lk_id;
  logic            lk_inc;
  logic            lk_clr;
  logic            lk_locked;

  assign any_flag = bus.invalid_login | bus.already_voted | bus.vote_done;
  assign flag_res = flag_code(bus.invalid_login, bus.already_voted);
  assign bus.busy = ~bus.req_ready;

  // Query the incoming id while idle, update the latched id when reporting.
  always_comb begin
    lk_id  = (state == S_IDLE) ? bus.req_id : bus.voter_id;
    lk_inc = (state == S_REPORT) && (bus.res_code == RES_BAD_PASS);
    lk_clr = (state == S_REPORT) && (bus.res_code == RES_OK);
  end

  voter_lockout #(.PASS_TRIES(PASS_TRIES)) u_lockout (
    .clk    (clk),
    .rst    (rst),
    .id     (lk_id),
    .inc    (lk_inc),
    .clr    (lk_clr),
    .locked (lk_locked)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.start     <= 1'b0;
      bus.submit    <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_code  <= RES_OK;
      bus.voter_id  <= '0;
      bus.password  <= '0;
      bus.vote      <= '0;
    end else begin
      bus.start     <= 1'b0;
      bus.submit    <= 1'b0;
      bus.res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            bus.voter_id  <= bus.req_id;
            bus.password  <= bus.req_pass;
            bus.vote      <= bus.req_vote;
            bus.req_ready <= 1'b0;
            if (bus.req_vote == VOTE_ILLEGAL) begin
              state         <= S_REPORT;
              bus.res_valid <= 1'b1;
              bus.res_code  <= RES_BAD_VOTE;
            end else if (lk_locked) begin
              state         <= S_REPORT;
              bus.res_valid <= 1'b1;
              bus.res_code  <= RES_LOCKED;
            end else begin
              state     <= S_START;
              bus.start <= 1'b1;
            end
          end
        end
        S_START: begin
          state <= S_GAP;
          cnt   <= 8'(GAP - 1);
        end
        S_GAP: begin
          if (any_flag) begin
            state         <= S_REPORT;
            bus.res_valid <= 1'b1;
            bus.res_code  <= flag_res;
          end else if (cnt == 8'd0) begin
            state      <= S_SUBMIT;
            bus.submit <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_SUBMIT: begin
          if (any_flag) begin
            state         <= S_REPORT;
            bus.res_valid <= 1'b1;
            bus.res_code  <= flag_res;
          end else begin
            state <= S_WAIT;
            cnt   <= 8'(RESP_TIMEOUT - 1);
          end
        end
        S_WAIT: begin
          // A flag in the last window cycle still wins over the timeout.
          if (any_flag) begin
            state         <= S_REPORT;
            bus.res_valid <= 1'b1;
            bus.res_code  <= flag_res;
          end else if (cnt == 8'd0) begin
            state         <= S_REPORT;
            bus.res_valid <= 1'b1;
            bus.res_code  <= RES_TIMEOUT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_REPORT: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
